// File: rtl/pipeline_run_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_run_ctrl
//
// Run/step/halt controller for a 5-stage pipeline. It decides when the
// pipeline stage registers and the PC may be written, flushes wrong-path
// work on a taken branch, drains the instructions that are still in flight
// behind a HALT, and counts the cycles in which the pipeline advanced.
//
// Parameters
//   NBITS         width of the enabled-cycle counter
//   DRAIN_CYCLES  cycles needed to retire the instructions in ID..WB once a
//                 HALT has been seen in ID (must be >= 1)
//
// Ports
//   i_clk            clock; all state updates on the rising edge
//   i_reset          asynchronous reset, active low
//   i_run            level request for continuous execution
//   i_step           one-cycle pulse requesting a single pipeline advance
//   i_clear          one-cycle pulse: HALTED -> IDLE, zeroes the counter
//                    (only honoured in IDLE or HALTED)
//   i_halt_detected  a HALT opcode currently sits in ID
//   i_branch_taken   taken-branch indication from the EX/MEM register
//   o_enable         write-enable for every pipeline stage register
//   o_pc_enable      write-enable for the PC
//   o_flush          zero the control fields of IF/ID, ID/EX and EX/MEM
//   o_halted         controller is parked in HALTED
//   o_busy           controller is in RUN, STEP or DRAIN
//   o_cycle_count    saturating count of cycles with o_enable = 1
//
// o_enable, o_halted and o_busy come straight from flops so they are stable
// well before the falling edge on which the stage registers latch.
// o_pc_enable and o_flush must react to ID / EX-MEM in the same cycle, so
// they are a thin combinational gate on top of the registered enable.
// ---------------------------------------------------------------------------
module pipeline_run_ctrl #(
    parameter int NBITS        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_clear,
    input  logic             i_halt_detected,
    input  logic             i_branch_taken,
    output logic             o_enable,
    output logic             o_pc_enable,
    output logic             o_flush,
    output logic             o_halted,
    output logic             o_busy,
    output logic [NBITS-1:0] o_cycle_count
);

    // Drain counter is wide enough to hold DRAIN_CYCLES itself.
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(32'd1);
    localparam logic [DW-1:0]    DRAIN_ZERO = {DW{1'b0}};
    localparam logic [NBITS-1:0] COUNT_MAX  = {NBITS{1'b1}};
    localparam logic [NBITS-1:0] COUNT_ZERO = {NBITS{1'b0}};
    localparam logic [NBITS-1:0] COUNT_ONE  = NBITS'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Origin of a drain: which state to resume if the HALT turns out to be
    // on the wrong path of a taken branch.
    localparam logic ORIGIN_RUN  = 1'b0;
    localparam logic ORIGIN_STEP = 1'b1;

    state_t           state_r;
    state_t           state_next_s;
    logic [DW-1:0]    drain_cnt_r;
    logic [DW-1:0]    drain_next_s;
    logic             origin_r;
    logic             origin_next_s;
    logic             enable_r;
    logic             halted_r;
    logic             busy_r;
    logic [NBITS-1:0] count_r;
    logic             clear_ok_s;
    logic             pc_enable_s;
    logic             flush_s;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [NBITS-1:0] sat_inc(input logic [NBITS-1:0] value);
        logic [NBITS-1:0] result;
        if (value == COUNT_MAX) begin
            result = value;
        end else begin
            result = value + COUNT_ONE;
        end
        return result;
    endfunction

    // States in which the pipeline registers advance.
    function automatic logic advances(input state_t s);
        logic result;
        case (s)
            ST_RUN:   result = 1'b1;
            ST_STEP:  result = 1'b1;
            ST_DRAIN: result = 1'b1;
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

    // Next-state, drain-counter and origin selection.
    always_comb begin
        state_next_s  = state_r;
        drain_next_s  = drain_cnt_r;
        origin_next_s = origin_r;
        case (state_r)
            ST_IDLE: begin
                // Continuous run wins over a single step when both arrive.
                if (i_run) begin
                    state_next_s = ST_RUN;
                end else if (i_step) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A HALT in ID takes priority over i_run being dropped.
                if (i_halt_detected) begin
                    state_next_s  = ST_DRAIN;
                    drain_next_s  = DRAIN_LOAD;
                    origin_next_s = ORIGIN_RUN;
                end else if (!i_run) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STEP: begin
                // Exactly one advance; further i_step pulses are not looked at.
                if (i_halt_detected) begin
                    state_next_s  = ST_DRAIN;
                    drain_next_s  = DRAIN_LOAD;
                    origin_next_s = ORIGIN_STEP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // A taken branch behind the HALT means the HALT was fetched on
                // the wrong path: it gets flushed, so resume where we came from.
                if (i_branch_taken) begin
                    state_next_s = (origin_r == ORIGIN_STEP) ? ST_IDLE : ST_RUN;
                    drain_next_s = DRAIN_ZERO;
                end else if (drain_cnt_r <= DRAIN_LAST) begin
                    // "<=" also recovers from a corrupted zero count.
                    state_next_s = ST_HALTED;
                    drain_next_s = DRAIN_ZERO;
                end else begin
                    state_next_s = ST_DRAIN;
                    drain_next_s = drain_cnt_r - DRAIN_LAST;
                end
            end
            ST_HALTED: begin
                if (i_clear) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HALTED;
                end
            end
            default: begin
                // Unreachable encodings fall back to a safe parked state.
                state_next_s  = ST_IDLE;
                drain_next_s  = DRAIN_ZERO;
                origin_next_s = ORIGIN_RUN;
            end
        endcase
    end

    // Counter clear is honoured only while the pipeline is not advancing.
    always_comb begin
        case (state_r)
            ST_IDLE:   clear_ok_s = i_clear;
            ST_HALTED: clear_ok_s = i_clear;
            default:   clear_ok_s = 1'b0;
        endcase
    end

    // FSM state plus registered Moore outputs derived from the next state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= DRAIN_ZERO;
            origin_r    <= ORIGIN_RUN;
            enable_r    <= 1'b0;
            halted_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            drain_cnt_r <= drain_next_s;
            origin_r    <= origin_next_s;
            enable_r    <= advances(state_next_s);
            halted_r    <= (state_next_s == ST_HALTED);
            busy_r      <= advances(state_next_s);
        end
    end

    // Saturating count of cycles in which the pipeline advanced.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count_r <= COUNT_ZERO;
        end else if (clear_ok_s) begin
            count_r <= COUNT_ZERO;
        end else if (enable_r) begin
            count_r <= sat_inc(count_r);
        end else begin
            count_r <= count_r;
        end
    end

    // Same-cycle gating: the PC freezes as soon as a HALT reaches ID and for
    // the whole drain; a taken branch flushes only while stages advance.
    always_comb begin
        if (enable_r && !i_halt_detected && (state_r != ST_DRAIN)) begin
            pc_enable_s = 1'b1;
        end else begin
            pc_enable_s = 1'b0;
        end
        if (enable_r && i_branch_taken) begin
            flush_s = 1'b1;
        end else begin
            flush_s = 1'b0;
        end
    end

    assign o_enable      = enable_r;
    assign o_pc_enable   = pc_enable_s;
    assign o_flush       = flush_s;
    assign o_halted      = halted_r;
    assign o_busy        = busy_r;
    assign o_cycle_count = count_r;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Testbench for pipeline_run_ctrl: directed scenarios with hand-computed
// expectations followed by randomized stimulus, all checked every cycle
// against a behavioural model. A second instance with a 4-bit counter
// shares the inputs so saturation is exercised.
module tb_pipeline_run_ctrl;

    localparam int DC = 4;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STEP   = 2;
    localparam int M_DRAIN  = 3;
    localparam int M_HALTED = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, step, clr, halt, br;
    logic        en, pc_en, flush, halted, busy;
    logic [31:0] cnt;
    logic        en4, pc_en4, flush4, halted4, busy4;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_run_ctrl #(.NBITS(32), .DRAIN_CYCLES(DC)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_run(run), .i_step(step),
        .i_clear(clr), .i_halt_detected(halt), .i_branch_taken(br),
        .o_enable(en), .o_pc_enable(pc_en), .o_flush(flush),
        .o_halted(halted), .o_busy(busy), .o_cycle_count(cnt)
    );

    pipeline_run_ctrl #(.NBITS(4), .DRAIN_CYCLES(DC)) dut4 (
        .i_clk(clk), .i_reset(rst_n), .i_run(run), .i_step(step),
        .i_clear(clr), .i_halt_detected(halt), .i_branch_taken(br),
        .o_enable(en4), .o_pc_enable(pc_en4), .o_flush(flush4),
        .o_halted(halted4), .o_busy(busy4), .o_cycle_count(cnt4)
    );

    // ---------------- behavioural model ----------------
    // Mode, a drain deadline expressed as an absolute cycle number, and the
    // plain number of enabled cycles since the last clear.
    int     m_mode      = M_IDLE;
    longint m_cyc       = 0;
    longint m_done_at   = 0;
    longint m_enabled   = 0;
    bit     m_from_step = 1'b0;

    function automatic bit mode_advances(input int mode);
        return (mode == M_RUN) || (mode == M_STEP) || (mode == M_DRAIN);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode      <= M_IDLE;
            m_enabled   <= 0;
            m_from_step <= 1'b0;
            m_done_at   <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (mode_advances(m_mode))
                m_enabled <= m_enabled + 1;
            else if (clr && (m_mode == M_IDLE || m_mode == M_HALTED))
                m_enabled <= 0;
            case (m_mode)
                M_IDLE: begin
                    if (run) m_mode <= M_RUN;
                    else if (step) m_mode <= M_STEP;
                end
                M_RUN: begin
                    if (halt) begin
                        m_mode <= M_DRAIN; m_done_at <= m_cyc + DC; m_from_step <= 1'b0;
                    end else if (!run) m_mode <= M_IDLE;
                end
                M_STEP: begin
                    if (halt) begin
                        m_mode <= M_DRAIN; m_done_at <= m_cyc + DC; m_from_step <= 1'b1;
                    end else m_mode <= M_IDLE;
                end
                M_DRAIN: begin
                    if (br) m_mode <= m_from_step ? M_IDLE : M_RUN;
                    else if (m_cyc == m_done_at) m_mode <= M_HALTED;
                end
                M_HALTED: begin
                    if (clr) m_mode <= M_IDLE;
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- compare process ----------------
    logic        e_en, e_pc, e_fl, e_hl;
    logic [31:0] e_cnt32;
    logic [3:0]  e_cnt4;

    always @(negedge clk) begin
        #2;
        e_en    = mode_advances(m_mode);
        e_pc    = e_en && !halt && (m_mode != M_DRAIN);
        e_fl    = e_en && br;
        e_hl    = (m_mode == M_HALTED);
        e_cnt32 = (m_enabled > 64'd4294967295) ? 32'hFFFF_FFFF : m_enabled[31:0];
        e_cnt4  = (m_enabled > 64'd15) ? 4'hF : m_enabled[3:0];
        check("m_enable",    {63'd0, en},     {63'd0, e_en});
        check("m_pc_enable", {63'd0, pc_en},  {63'd0, e_pc});
        check("m_flush",     {63'd0, flush},  {63'd0, e_fl});
        check("m_halted",    {63'd0, halted}, {63'd0, e_hl});
        check("m_busy",      {63'd0, busy},   {63'd0, e_en});
        check("m_count",     {32'd0, cnt},    {32'd0, e_cnt32});
        check("m_enable4",   {63'd0, en4},    {63'd0, e_en});
        check("m_pc_en4",    {63'd0, pc_en4}, {63'd0, e_pc});
        check("m_flush4",    {63'd0, flush4}, {63'd0, e_fl});
        check("m_halted4",   {63'd0, halted4},{63'd0, e_hl});
        check("m_busy4",     {63'd0, busy4},  {63'd0, e_en});
        check("m_count4",    {60'd0, cnt4},   {60'd0, e_cnt4});
    end

    // ---------------- stimulus ----------------
    // Apply inputs on the falling edge, return 3 time units later so the
    // caller can inspect this cycle's outputs.
    task automatic drive(input logic r, input logic ru, input logic st,
                         input logic cl, input logic h, input logic b);
        @(negedge clk);
        rst_n = r; run = ru; step = st; clr = cl; halt = h; br = b;
        #3;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_enable", {63'd0, en},     64'd0);
        check("rst_pc_en",  {63'd0, pc_en},  64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_count",  {32'd0, cnt},    64'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int  ens;
    logic rr;

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; clr = 1'b0; halt = 1'b0; br = 1'b0;

        // Three step pulses, three cycles apart.
        do_reset();
        ens = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, (k % 3 == 0) && (k < 9), 1'b0, 1'b0, 1'b0);
            if (en) ens++;
        end
        check("step_enables", 64'(ens), 64'd3);
        check("step_count", {32'd0, cnt}, 64'd3);
        check("step_idle", {63'd0, busy}, 64'd0);

        // Run with a HALT in ID at cycle 10.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, (k == 10), 1'b0);
            if (k <= 14) check("halt_enable", {63'd0, en}, 64'd1);
            if (k >= 10 && k <= 14) check("halt_pc_frozen", {63'd0, pc_en}, 64'd0);
            if (k == 15) begin
                check("halt_halted", {63'd0, halted}, 64'd1);
                check("halt_en_off", {63'd0, en}, 64'd0);
                check("halt_count", {32'd0, cnt}, 64'd15);
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("halted_ignores_run", {63'd0, halted}, 64'd1);
        check("halted_no_enable", {63'd0, en}, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("clear_cycle_count", {32'd0, cnt}, 64'd15);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("clear_to_idle", {63'd0, halted}, 64'd0);
        check("clear_count", {32'd0, cnt}, 64'd0);

        // Wrong-path HALT: branch taken on the second drain cycle.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, (k == 3), (k == 5));
            if (k == 5) begin
                check("wp_flush", {63'd0, flush}, 64'd1);
                check("wp_pc_frozen", {63'd0, pc_en}, 64'd0);
            end
            if (k == 6) begin
                check("wp_resume_busy", {63'd0, busy}, 64'd1);
                check("wp_pc_again", {63'd0, pc_en}, 64'd1);
                check("wp_not_halted", {63'd0, halted}, 64'd0);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation of the 4-bit counter.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_count4", {60'd0, cnt4}, 64'd15);
        check("sat_count32", {32'd0, cnt}, 64'd20);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a drain.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, (k == 1), 1'b0);
        check("pre_rst_draining", {63'd0, en}, 64'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("arst_enable", {63'd0, en},    64'd0);
        check("arst_flush",  {63'd0, flush}, 64'd0);
        check("arst_busy",   {63'd0, busy},  64'd0);
        check("arst_count",  {32'd0, cnt},   64'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_idle", {63'd0, en}, 64'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_step", {63'd0, en}, 64'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_step_end", {63'd0, en}, 64'd0);
        check("post_rst_count", {32'd0, cnt}, 64'd1);

        // Run beats step; clear while running is ignored.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("prio_run_wins", {63'd0, en}, 64'd1);
        check("prio_clear_ignored", {32'd0, cnt}, 64'd2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        rr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) rr = ~rr;
            drive(($urandom_range(0, 149) != 0), rr,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
